// File: rtl/field_packer.sv
`default_nettype none
// ============================================================================
// Module      : field_packer
// Description : Packs NUM_FIELDS narrow fields into one OUT_W-bit word. The
//               first field goes into the MSBs, and the bits above the packed
//               region are filled with pad bits. The block also keeps the
//               bitwise AND of all packed fields, and in_last flushes a
//               partial word early. Both sides use a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module field_packer #(
    parameter int FIELD_W    = 5,
    parameter int NUM_FIELDS = 3,
    parameter int OUT_W      = 16,
    parameter int PAD_ONES   = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [FIELD_W-1:0]                in_field,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    output logic [OUT_W-1:0]                  out_word,
    output logic [$clog2(NUM_FIELDS+1)-1:0]   out_count,
    output logic [FIELD_W-1:0]                out_and,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int   c_pk_w    = FIELD_W * NUM_FIELDS;
    localparam int   c_cnt_w   = $clog2(NUM_FIELDS + 1);
    localparam logic c_pad_bit = (PAD_ONES != 0);

    // Reject parameter sets that cannot hold a full word.
    if (NUM_FIELDS < 1) begin : g_bad_num_fields
        $error("field_packer: NUM_FIELDS must be at least 1");
    end
    if (OUT_W < c_pk_w) begin : g_bad_out_w
        $error("field_packer: OUT_W must be at least FIELD_W*NUM_FIELDS");
    end

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_pk_w-1:0]    r_slots;
    logic [c_pk_w-1:0]    w_slots_nxt;
    logic [FIELD_W-1:0]   r_and;
    logic [FIELD_W-1:0]   w_and_nxt;
    logic                 w_accept;

    // A held word can be replaced in the same cycle it is consumed.
    assign in_ready  = (r_state == S_FILL) || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_HOLD);
    assign out_count = r_cnt;
    assign out_and   = r_and;

    if (OUT_W > c_pk_w) begin : g_pad
        assign out_word = {{(OUT_W - c_pk_w){c_pad_bit}}, r_slots};
    end else begin : g_no_pad
        assign out_word = r_slots;
    end

    // Next-state logic: slot writes, AND accumulation and word hand-off.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_slots_nxt = r_slots;
        w_and_nxt   = r_and;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    for (int k = 0; k < NUM_FIELDS; k++) begin
                        if (r_cnt == c_cnt_w'(k)) begin
                            w_slots_nxt[c_pk_w-1-k*FIELD_W -: FIELD_W] = in_field;
                        end
                    end
                    w_and_nxt = r_and & in_field;
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    if ((r_cnt == c_cnt_w'(NUM_FIELDS - 1)) || in_last) begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    // Word consumed: start a fresh word, seeded if a field arrives now.
                    w_state_nxt = S_FILL;
                    w_cnt_nxt   = '0;
                    w_slots_nxt = '0;
                    w_and_nxt   = '1;
                    if (w_accept) begin
                        w_slots_nxt[c_pk_w-1 -: FIELD_W] = in_field;
                        w_and_nxt = in_field;
                        w_cnt_nxt = c_cnt_w'(1);
                        if ((NUM_FIELDS == 1) || in_last) begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // State register; asynchronous reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_slots <= '0;
            r_and   <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_slots <= w_slots_nxt;
            r_and   <= w_and_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_field_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_field_packer
// Description : Self-checking bench for field_packer. Two instances differ
//               only in PAD_ONES. A list-based reference model predicts the
//               outputs of both instances on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_field_packer;

    localparam int FW    = 5;
    localparam int NF    = 3;
    localparam int OUT_W = 16;
    localparam int PK    = FW * NF;
    localparam int CW    = $clog2(NF + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [FW-1:0]     in_field = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b0;

    logic              in_ready_z, in_ready_o;
    logic [OUT_W-1:0]  out_word_z, out_word_o;
    logic [CW-1:0]     out_count_z, out_count_o;
    logic [FW-1:0]     out_and_z, out_and_o;
    logic              out_valid_z, out_valid_o;

    int checks = 0;
    int failures = 0;

    // Reference model: fields of the word being collected, and the word on offer.
    logic [FW-1:0] cur_f [NF];
    int            cur_n = 0;
    logic [FW-1:0] pend_f [NF];
    int            pend_n = 0;
    bit            pend_v = 1'b0;

    always #5 clk = ~clk;

    field_packer #(.FIELD_W(FW), .NUM_FIELDS(NF), .OUT_W(OUT_W), .PAD_ONES(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_field(in_field), .in_valid(in_valid),
        .in_ready(in_ready_z), .in_last(in_last), .out_word(out_word_z),
        .out_count(out_count_z), .out_and(out_and_z), .out_valid(out_valid_z),
        .out_ready(out_ready)
    );

    field_packer #(.FIELD_W(FW), .NUM_FIELDS(NF), .OUT_W(OUT_W), .PAD_ONES(1)) dut_o (
        .clk(clk), .rst_n(rst_n), .in_field(in_field), .in_valid(in_valid),
        .in_ready(in_ready_o), .in_last(in_last), .out_word(out_word_o),
        .out_count(out_count_o), .out_and(out_and_o), .out_valid(out_valid_o),
        .out_ready(out_ready)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Visible word = pad region, then each field shifted into its slot from the top.
    task automatic model_view(input bit pad1, output logic [OUT_W-1:0] w,
                              output int n, output logic [FW-1:0] a);
        logic [FW-1:0] f [NF];
        if (pend_v) begin
            n = pend_n;
            f = pend_f;
        end else begin
            n = cur_n;
            f = cur_f;
        end
        w = pad1 ? OUT_W'((64'd1 << OUT_W) - (64'd1 << PK)) : '0;
        a = '1;
        for (int k = 0; k < n; k++) begin
            w = w | (OUT_W'(f[k]) << (PK - FW * (k + 1)));
            a = a & f[k];
        end
    endtask

    task automatic compare_all();
        logic [OUT_W-1:0] wz, wo;
        logic [FW-1:0]    a;
        int               n;
        bit               rdy;
        model_view(1'b0, wz, n, a);
        model_view(1'b1, wo, n, a);
        rdy = !pend_v || out_ready;
        cmp("in_ready_z",  32'(in_ready_z),  32'(rdy));
        cmp("in_ready_o",  32'(in_ready_o),  32'(rdy));
        cmp("out_valid_z", 32'(out_valid_z), 32'(pend_v));
        cmp("out_valid_o", 32'(out_valid_o), 32'(pend_v));
        cmp("out_word_z",  32'(out_word_z),  32'(wz));
        cmp("out_word_o",  32'(out_word_o),  32'(wo));
        cmp("out_count_z", 32'(out_count_z), 32'(n));
        cmp("out_count_o", 32'(out_count_o), 32'(n));
        cmp("out_and_z",   32'(out_and_z),   32'(a));
        cmp("out_and_o",   32'(out_and_o),   32'(a));
    endtask

    // Advance the model over the coming rising edge using the driven inputs.
    task automatic model_step();
        bit acc;
        acc = in_valid && (!pend_v || out_ready);
        if (pend_v && out_ready) pend_v = 1'b0;
        if (acc) begin
            cur_f[cur_n] = in_field;
            cur_n++;
            if (cur_n == NF || in_last) begin
                pend_f = cur_f;
                pend_n = cur_n;
                pend_v = 1'b1;
                cur_n  = 0;
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [FW-1:0] f, input bit l, input bit r);
        @(negedge clk);
        in_valid  = v;
        in_field  = f;
        in_last   = l;
        out_ready = r;
        #1;
        compare_all();
        model_step();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n  = 1'b0;
        cur_n  = 0;
        pend_v = 1'b0;
        #1;
        compare_all();
        cmp("rst_valid", 32'(out_valid_z), 32'h0);
        cmp("rst_count", 32'(out_count_z), 32'h0);
        cmp("rst_and",   32'(out_and_z),   32'h1F);
        cmp("rst_word_z", 32'(out_word_z), 32'h0000);
        cmp("rst_word_o", 32'(out_word_o), 32'h8000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        apply_reset();

        // Full word, then word consumed.
        cycle(1'b1, 5'h1F, 1'b0, 1'b1);
        cycle(1'b1, 5'h00, 1'b0, 1'b1);
        cycle(1'b1, 5'h15, 1'b0, 1'b1);
        cycle(1'b0, 5'h00, 1'b0, 1'b1);
        cmp("full_valid",  32'(out_valid_z), 32'h1);
        cmp("full_word_z", 32'(out_word_z),  32'h7C15);
        cmp("full_word_o", 32'(out_word_o),  32'hFC15);
        cmp("full_count",  32'(out_count_z), 32'h3);
        cmp("full_and",    32'(out_and_z),   32'h00);
        cycle(1'b0, 5'h00, 1'b0, 1'b1);
        cmp("full_taken",  32'(out_valid_z), 32'h0);

        // Early flush of a single field.
        cycle(1'b1, 5'h0A, 1'b1, 1'b1);
        cycle(1'b0, 5'h00, 1'b0, 1'b1);
        cmp("flush_word_z", 32'(out_word_z),  32'h2800);
        cmp("flush_word_o", 32'(out_word_o),  32'hA800);
        cmp("flush_count",  32'(out_count_z), 32'h1);
        cmp("flush_and",    32'(out_and_z),   32'h0A);

        // Backpressure for five cycles with input offered.
        cycle(1'b1, 5'h01, 1'b0, 1'b1);
        cycle(1'b1, 5'h02, 1'b0, 1'b1);
        cycle(1'b1, 5'h03, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
            cmp("bp_in_ready", 32'(in_ready_z),  32'h0);
            cmp("bp_word",     32'(out_word_z),  32'h0443);
            cmp("bp_count",    32'(out_count_z), 32'h3);
            cmp("bp_and",      32'(out_and_z),   32'h00);
        end
        cycle(1'b0, 5'h00, 1'b0, 1'b1);
        cmp("bp_release_valid", 32'(out_valid_z), 32'h1);
        cycle(1'b0, 5'h00, 1'b0, 1'b1);
        cmp("bp_taken_once", 32'(out_valid_z), 32'h0);

        // Back-to-back words with no bubble.
        cycle(1'b1, 5'h07, 1'b0, 1'b1);
        cycle(1'b1, 5'h08, 1'b0, 1'b1);
        cycle(1'b1, 5'h09, 1'b0, 1'b1);
        cycle(1'b1, 5'h03, 1'b0, 1'b1);
        cmp("b2b_first_valid", 32'(out_valid_z), 32'h1);
        cycle(1'b1, 5'h04, 1'b0, 1'b1);
        cycle(1'b1, 5'h05, 1'b0, 1'b1);
        cycle(1'b0, 5'h00, 1'b0, 1'b1);
        cmp("b2b_word",  32'(out_word_z),        32'h0C85);
        cmp("b2b_slot0", 32'(out_word_z[14:10]), 32'h03);

        // Reset in the middle of a word.
        cycle(1'b1, 5'h11, 1'b0, 1'b1);
        cycle(1'b1, 5'h12, 1'b0, 1'b1);
        apply_reset();
        cycle(1'b1, 5'h01, 1'b0, 1'b1);
        cycle(1'b1, 5'h02, 1'b0, 1'b1);
        cycle(1'b1, 5'h03, 1'b0, 1'b1);
        cycle(1'b0, 5'h00, 1'b0, 1'b1);
        cmp("post_rst_word",  32'(out_word_z),  32'h0443);
        cmp("post_rst_count", 32'(out_count_z), 32'h3);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 500) apply_reset();
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/field_packer.md
Name: field_packer

Overview:
- Parametrised, registered successor to the fixed bit-slice/concatenate/AND-gate number logic.
- Accepts narrow fields one per handshake and packs NUM_FIELDS of them, by concatenation, into one OUT_W-bit word, with configurable pad fill above the packed region.
- Also produces the per-bit AND of all packed fields, and supports early flush of a partial word.
- Sits between narrow field producers and wide word consumers, with valid/ready on both sides.

Parameters:
- FIELD_W, 5, width of one input field.
- NUM_FIELDS, 3, fields per full word; must be ≥1.
- OUT_W, 16, output word width; must be ≥ FIELD_W*NUM_FIELDS (elaboration error otherwise).
- PAD_ONES, 0, 0 = upper pad bits are zero, 1 = upper pad bits are one.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_field  in  FIELD_W  field data.
- in_valid  in  1  in_field valid.
- in_ready  out  1  packer can accept a field this cycle.
- in_last  in  1  qualifies accepted field as last of a word (early flush).
- out_word  out  OUT_W  packed word.
- out_count  out  $clog2(NUM_FIELDS+1)  number of fields packed into out_word.
- out_and  out  FIELD_W  bitwise AND of all fields in out_word.
- out_valid  out  1  out_word/out_count/out_and valid.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Define PK = FIELD_W*NUM_FIELDS.
- Slot k (k = 0 first accepted) occupies out_word[PK-1-k*FIELD_W -: FIELD_W]: first field in MSBs, matching {f0,f1,...} concatenation order.
- out_word[OUT_W-1:PK] = all PAD_ONES; present whenever OUT_W > PK.
- Unfilled slots read zero.
- States:
  - FILL: collecting; out_valid=0.
  - HOLD: word presented; out_valid=1.
- in_ready = (state==FILL) | (state==HOLD & out_ready).
- Accept = in_valid & in_ready.
- FILL transitions:
  - On accept: write in_field into slot cnt; out_and <= out_and & in_field; cnt++.
  - If cnt was NUM_FIELDS-1 or in_last=1: go to HOLD next cycle.
  - Latency is one cycle from the final accept to out_valid.
- HOLD transitions:
  - Outputs are stable while out_ready=0.
  - On out_ready=1 with no accept: go to FILL; cnt=0; slots zeroed; out_and=all ones.
  - On out_ready=1 with accept in the same cycle: the new field lands in slot 0 of a fresh word (other slots zero, out_and=in_field, cnt=1). Go to HOLD if NUM_FIELDS==1 or in_last, else FILL. No bubble.
- out_count = cnt; it is never 0 while out_valid=1.
- in_last on a field that also fills the last slot behaves the same as a full word.
- in_field/in_last are ignored when not accepted.
- Reset (async assert, any state, including mid-word):
  - State FILL, cnt=0, out_valid=0.
  - out_word = pad pattern with zero slots.
  - out_count=0; out_and=all ones.
  - Partial word is discarded.
- Deassertion is synchronised by the integrator; the first accept may occur on the first clock after release.
- No combinational path from in_valid to out_valid.
- in_ready depends combinationally on out_ready only.

Test Plan (defaults FIELD_W=5, NUM_FIELDS=3, OUT_W=16, PAD_ONES=0 unless stated):
- Full word: accept 0x1F, 0x00, 0x15 on consecutive cycles with out_ready=1 -> next cycle out_valid=1, out_word=0x7C15, out_count=3, out_and=0x00; in the following cycle out_valid=0.
- Early flush: accept 0x0A with in_last=1 -> out_word=0x2800, out_count=1, out_and=0x0A.
- Pad fill with PAD_ONES=1: repeat the full-word scenario -> out_word=0xFC15.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_word/out_count/out_and stable, in_ready=0, in_valid ignored. Then raise out_ready -> word taken once.
- Back-to-back: in HOLD with out_ready=1 and in_valid=1, in_field=0x03 -> new word slot 0 = 0x03 (out_word bits 14:10 = 00011 when completed). Continuous valid input yields one word every 3 cycles with no gap.
- Reset mid-word: accept 0x11, 0x12, then pulse rst_n low -> out_valid=0, out_count=0, out_and=0x1F. Then accept 0x01, 0x02, 0x03 -> out_word=0x0443, out_count=3.
